// File: rtl/conv_mac_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_pkg                                                                  |
// | Width derivations and the round/shift/saturate helper for conv_mac_pipe.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package conv_pkg;

   localparam int c_RS_W = 64;

   typedef struct packed {
      logic signed [c_RS_W-1:0] data;
      logic                     sat;
   } rs_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) r++;
      return r;
   endfunction

   function automatic int p_w_of(input int wei_w, input int ima_w);
      return wei_w + ima_w + 1;
   endfunction

   function automatic int d_of(input int taps);
      return clog2(taps + 1);
   endfunction

   function automatic int acc_w_of(input int wei_w, input int ima_w, input int taps);
      return p_w_of(wei_w, ima_w) + d_of(taps);
   endfunction

   // Number of operands entering adder level lvl of a tree with the given leaf count.
   function automatic int n_level(input int leaves, input int lvl);
      int n;
      n = leaves;
      for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
      return n;
   endfunction

   function automatic rs_t round_sat(input logic signed [c_RS_W-1:0] acc,
                                     input int shift, input int width);
      logic signed [c_RS_W-1:0] r, hi, lo;
      rs_t o;
      r = acc;
      if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      o.data = r;
      o.sat  = 1'b0;
      if (r > hi) begin
         o.data = hi;
         o.sat  = 1'b1;
      end else if (r < lo) begin
         o.data = lo;
         o.sat  = 1'b1;
      end
      return o;
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_pipe_add_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_add_stage                                                            |
// | One registered pairwise adder level; an odd last operand passes through.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module conv_add_stage
   import conv_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_en,
   input  logic                          i_valid,
   input  logic [N*W-1:0]                i_data,
   output logic                          o_valid,
   output logic [((N+1)/2)*(W+1)-1:0]    o_data
);

   localparam int c_NO = (N + 1) / 2;

   logic [c_NO*(W+1)-1:0] w_sum;

   generate
      for (genvar g = 0; g < c_NO; g++) begin : g_pair
         logic signed [W:0] w_a;
         assign w_a = {i_data[(2*g+1)*W-1], i_data[2*g*W +: W]};
         if (2*g + 1 < N) begin : g_add
            logic signed [W:0] w_b;
            assign w_b = {i_data[(2*g+2)*W-1], i_data[(2*g+1)*W +: W]};
            assign w_sum[g*(W+1) +: W+1] = w_a + w_b;
         end else begin : g_pass
            assign w_sum[g*(W+1) +: W+1] = w_a;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)       o_valid <= 1'b0;
      else if (i_en) o_valid <= i_valid;
   end

   always_ff @(posedge clk) begin
      if (i_en) o_data <= w_sum;
   end

endmodule
`default_nettype wire

// File: rtl/conv_mac_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_mac_pipe                                                             |
// | Pipelined KxK signed MAC + bias, round/shift/saturate, valid/ready stall. |
// | Optional CONV_RELU_EN clamps negative results to zero.                    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module conv_mac_pipe
   import conv_pkg::*;
#(
   parameter int K         = 7,
   parameter int WEI_W     = 16,
   parameter int FRAC      = 8,
   parameter int IMA_W     = 8,
   parameter int BIAS_W    = 16,
   parameter int OUT_W     = 16,
   parameter int OUT_SHIFT = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WEI_W*K*K-1:0]   wei,
   input  logic [IMA_W*K*K-1:0]   ima,
   input  logic [BIAS_W-1:0]      bias,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_sat
);

   localparam int c_TAPS   = K * K;
   localparam int c_LEAVES = c_TAPS + 1;
   localparam int c_P_W    = p_w_of(WEI_W, IMA_W);
   localparam int c_D      = d_of(c_TAPS);
   localparam int c_ACC_W  = acc_w_of(WEI_W, IMA_W, c_TAPS);

   logic                        w_adv;
   logic [c_LEAVES*c_P_W-1:0]   w_leaf;
   logic [c_LEAVES*c_P_W-1:0]   r_leaf;
   logic                        r_v0;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   // Pixels are zero-extended so the signed multiply treats them as unsigned.
   generate
      for (genvar i = 0; i < c_TAPS; i++) begin : g_mul
         logic signed [c_P_W-1:0] w_a, w_b;
         assign w_a = {{(c_P_W-WEI_W){wei[i*WEI_W+WEI_W-1]}}, wei[i*WEI_W +: WEI_W]};
         assign w_b = {{(c_P_W-IMA_W){1'b0}}, ima[i*IMA_W +: IMA_W]};
         assign w_leaf[i*c_P_W +: c_P_W] = w_a * w_b;
      end
   endgenerate

   assign w_leaf[c_TAPS*c_P_W +: c_P_W] = {{(c_P_W-BIAS_W){bias[BIAS_W-1]}}, bias};

   always_ff @(posedge clk) begin
      if (rst)        r_v0 <= 1'b0;
      else if (w_adv) r_v0 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (w_adv) r_leaf <= w_leaf;
   end

   generate
      for (genvar l = 0; l < c_D; l++) begin : g_lvl
         localparam int c_N  = n_level(c_LEAVES, l);
         localparam int c_W  = c_P_W + l;
         localparam int c_NO = (c_N + 1) / 2;
         logic [c_N*c_W-1:0]       w_d;
         logic                     w_dv;
         logic [c_NO*(c_W+1)-1:0]  w_q;
         logic                     w_qv;
         if (l == 0) begin : g_first
            assign w_d  = r_leaf;
            assign w_dv = r_v0;
         end else begin : g_next
            assign w_d  = g_lvl[l-1].w_q;
            assign w_dv = g_lvl[l-1].w_qv;
         end
         conv_add_stage #(.N(c_N), .W(c_W)) u_add (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_adv),
            .i_valid (w_dv),
            .i_data  (w_d),
            .o_valid (w_qv),
            .o_data  (w_q)
         );
      end
   endgenerate

   logic signed [c_ACC_W-1:0] w_acc;
   logic                      w_accv;
   rs_t                       w_rs;
   logic [OUT_W-1:0]          w_data;
   logic                      w_sat;

   assign w_acc  = g_lvl[c_D-1].w_q;
   assign w_accv = g_lvl[c_D-1].w_qv;

   always_comb begin
      w_rs   = round_sat({{(c_RS_W-c_ACC_W){w_acc[c_ACC_W-1]}}, w_acc}, OUT_SHIFT, OUT_W);
      w_data = w_rs.data[OUT_W-1:0];
      w_sat  = w_rs.sat;
`ifdef CONV_RELU_EN
      if (w_data[OUT_W-1]) begin
         w_data = '0;
         w_sat  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (w_adv) begin
         out_valid <= w_accv;
         if (w_accv) begin
            out_data <= w_data;
            out_sat  <= w_sat;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_mac_pipe                                                          |
// | Directed and random checks of conv_mac_pipe against an arithmetic model.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_conv_mac_pipe;

   localparam int K = 7, TAPS = K * K, WEI_W = 16, FRAC = 8, IMA_W = 8;
   localparam int BIAS_W = 16, OUT_W = 16, OUT_SHIFT = 8, L = 8;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid, in_ready, out_valid, out_ready, out_sat;
   logic [WEI_W*TAPS-1:0]   wei;
   logic [IMA_W*TAPS-1:0]   ima;
   logic [BIAS_W-1:0]       bias;
   logic [OUT_W-1:0]        out_data;

   int     wei_a [TAPS];
   int     ima_a [TAPS];
   int     bias_v;
   longint exp_q [$];
   bit     sat_q [$];
   int     n_assert = 0, n_fail = 0, n_out = 0;
   bit     dir_en = 0, dir_sat;
   longint dir_data;

   conv_mac_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wei       (wei),
      .ima       (ima),
      .bias      (bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   // Reference: exact integer dot product, floor((sum + half) / 2^shift), clip.
   task automatic ref_model(output longint d, output bit s);
      longint acc, r, hi, lo;
      acc = bias_v;
      for (int i = 0; i < TAPS; i++) acc += longint'(wei_a[i]) * longint'(ima_a[i]);
      r  = (acc + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -(longint'(1) << (OUT_W - 1));
      s  = 0;
      if (r > hi) begin r = hi; s = 1; end
      if (r < lo) begin r = lo; s = 1; end
`ifdef CONV_RELU_EN
      if (r < 0) begin r = 0; s = 0; end
`endif
      d = r;
   endtask

   task automatic set_all(input int w, input int p, input int b);
      for (int i = 0; i < TAPS; i++) begin
         wei_a[i] = w;
         ima_a[i] = p;
      end
      bias_v = b;
   endtask

   task automatic set_random();
      for (int i = 0; i < TAPS; i++) begin
         if ($urandom_range(0, 9) == 0) wei_a[i] = int'($signed(16'($urandom)));
         else                           wei_a[i] = int'($urandom_range(0, 2047)) - 1024;
         ima_a[i] = int'($urandom_range(0, 255));
      end
      bias_v = int'($signed(16'($urandom)));
   endtask

   // One clock: drive buses, account acceptance/consumption, advance to edge+1.
   task automatic step(output bit took);
      longint e;
      bit     es, cons;
      for (int i = 0; i < TAPS; i++) begin
         wei[i*WEI_W +: WEI_W] = WEI_W'(wei_a[i]);
         ima[i*IMA_W +: IMA_W] = IMA_W'(ima_a[i]);
      end
      bias = BIAS_W'(bias_v);
      #1;
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      took = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (took) begin
         if (dir_en) begin
            exp_q.push_back(dir_data);
            sat_q.push_back(dir_sat);
         end else begin
            ref_model(e, es);
            exp_q.push_back(e);
            sat_q.push_back(es);
         end
      end
      if (cons) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check("spurious_out", out_valid, 1'b0);
         end else begin
            e  = exp_q.pop_front();
            es = sat_q.pop_front();
            check("out_data", $signed(out_data), e);
            check("out_sat", out_sat, es);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic latency_run(input string tag);
      bit t;
      int cyc;
      in_valid = 1;
      step(t);
      in_valid = 0;
      cyc = 1;
      while (!out_valid && cyc < 30) begin
         step(t);
         cyc++;
      end
      check(tag, cyc, L);
      step(t);
   endtask

   task automatic send_dir(input int w, input int p, input int b, input longint d, input bit s);
      bit t;
      set_all(w, p, b);
      dir_en   = 1;
      dir_data = d;
      dir_sat  = s;
      in_valid = 1;
      step(t);
      dir_en   = 0;
   endtask

   task automatic drain();
      bit t;
      in_valid  = 0;
      out_ready = 1;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(t);
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      bit took;
      int k, base;
      rst = 1; in_valid = 0; out_ready = 1;
      set_all(0, 0, 0);
      wei = '0; ima = '0; bias = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_data", $signed(out_data), 0);
      check("reset_out_sat", out_sat, 1'b0);
      rst = 0;
      #1;
      check("reset_in_ready", in_ready, 1'b1);

      // Latency with unit weights (1.0 in FRAC format) and unit pixels.
      set_all(1 << FRAC, 1, 0);
      dir_en = 1; dir_data = 49; dir_sat = 0;
      latency_run("latency");
      dir_en = 0;

      // Directed boundaries, back to back.
      send_dir(0, 0, 128, 1, 0);
      send_dir(0, 0, 127, 0, 0);
      send_dir(32767, 255, 0, 32767, 1);
`ifdef CONV_RELU_EN
      send_dir(-32768, 255, 0, 0, 0);
      send_dir(-256, 1, 0, 0, 0);
`else
      send_dir(-32768, 255, 0, -32768, 1);
      send_dir(-256, 1, 0, -49, 0);
`endif
      drain();

      // Backpressure: 12 windows, output stalled for 5 cycles mid-stream.
      base = n_out;
      k = 0;
      set_all(0, 0, 0);
      for (int i = 0; i < TAPS; i++) ima_a[i] = int'($urandom_range(0, 255));
      for (int t = 0; t < 40; t++) begin
         in_valid  = (k < 12);
         bias_v    = k * 256;
         out_ready = !(t >= 9 && t < 14);
         step(took);
         if (took) k++;
      end
      check("bp_accepted", k, 12);
      check("bp_outputs", n_out - base, 12);
      drain();

      // Reset with windows in flight; nothing stale may emerge afterwards.
      in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         set_random();
         step(took);
      end
      in_valid = 0;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      exp_q.delete();
      sat_q.delete();
      check("midrst_out_valid", out_valid, 1'b0);
      base = n_out;
      for (int i = 0; i < 12; i++) step(took);
      check("midrst_no_output", n_out - base, 0);
      set_random();
      latency_run("latency_after_reset");

      // Random traffic with random backpressure.
      for (int n = 0; n < 400; n++) begin
         set_random();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         step(took);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
